// File: rtl/mult_share_ctrl_pkg.sv
// rtl/mult_share_ctrl_pkg.sv - shared types and widths for the shared multiplier controller
// Purpose: state encoding, operand/product widths and the requester-id width helper.
// Ports: none (package).
package mult_ctrl_pkg;

  localparam int OP_W   = 8;
  localparam int PROD_W = 16;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETTLE = 2'd1,
    ST_DONE   = 2'd2
  } state_t;

  // Requester id width; a single-bit id is kept even for tiny requester counts.
  function automatic int id_width(input int n_req);
    return (n_req <= 2) ? 1 : $clog2(n_req);
  endfunction

endpackage

// File: rtl/mult_share_ctrl_if.sv
// rtl/mult_share_ctrl_if.sv - request/response/status bundle of the shared multiplier
// Purpose: groups per-requester operand handshakes, the product response and status.
// Ports (signals): req_valid/req_ready/req_a/req_b (requesters), rsp_valid/rsp_ready/
//   rsp_product/rsp_id (consumer), busy/ops_count (status).
// Modports: master = requesters + consumer side, slave = controller side.
interface mult_share_ctrl_if
  import mult_ctrl_pkg::*;
#(
  parameter int N_REQ = 2,
  parameter int ID_W  = 1
) ();

  logic [N_REQ-1:0]      req_valid;
  logic [N_REQ-1:0]      req_ready;
  logic [OP_W*N_REQ-1:0] req_a;
  logic [OP_W*N_REQ-1:0] req_b;
  logic                  rsp_valid;
  logic                  rsp_ready;
  logic [PROD_W-1:0]     rsp_product;
  logic [ID_W-1:0]       rsp_id;
  logic                  busy;
  logic [15:0]           ops_count;

  modport master (
    output req_valid, req_a, req_b, rsp_ready,
    input  req_ready, rsp_valid, rsp_product, rsp_id, busy, ops_count
  );

  modport slave (
    input  req_valid, req_a, req_b, rsp_ready,
    output req_ready, rsp_valid, rsp_product, rsp_id, busy, ops_count
  );

endinterface

// File: rtl/mult_share_ctrl_arbiter.sv
// rtl/mult_share_ctrl_arbiter.sv - combinational round-robin arbiter
// Purpose: picks the first asserted request at or after ptr, wrapping around.
// Ports: req (request vector), ptr (highest-priority index),
//   grant (one-hot or zero), id (encoded index of the grant, 0 when none).
module mult_rr_arbiter
  import mult_ctrl_pkg::*;
#(
  parameter int N_REQ = 2,
  parameter int ID_W  = id_width(N_REQ)
) (
  input  logic [N_REQ-1:0] req,
  input  logic [ID_W-1:0]  ptr,
  output logic [N_REQ-1:0] grant,
  output logic [ID_W-1:0]  id
);

  always_comb begin
    int  idx;
    logic found;
    grant = '0;
    id    = '0;
    found = 1'b0;
    idx   = 0;
    for (int k = 0; k < N_REQ; k++) begin
      idx = (int'(ptr) + k) % N_REQ;
      if (!found && req[idx]) begin
        found      = 1'b1;
        grant[idx] = 1'b1;
        id         = ID_W'(idx);
      end
    end
  end

endmodule

// File: rtl/mult_share_ctrl_mult.sv
// rtl/mult_share_ctrl_mult.sv - unsigned 8x8 ripple array multiplier
// Purpose: purely combinational shift-and-add array; deep ripple, so callers hold inputs
//   stable for several cycles before sampling the product.
// Ports: a, b (8-bit operands), product (16-bit unsigned result).
module mult_array8
  import mult_ctrl_pkg::*;
(
  input  logic [OP_W-1:0]   a,
  input  logic [OP_W-1:0]   b,
  output logic [PROD_W-1:0] product
);

  // Each row adds one shifted partial product; 255*255 fits in 16 bits, so no carry-out.
  always_comb begin
    logic [PROD_W-1:0] acc;
    acc = '0;
    for (int i = 0; i < OP_W; i++) begin
      if (b[i]) begin
        acc = acc + (PROD_W'(a) << i);
      end
    end
    product = acc;
  end

endmodule

// File: rtl/mult_share_ctrl.sv
// rtl/mult_share_ctrl.sv - shares one array multiplier between N_REQ requesters
// Purpose: round-robin accept, hold latched operands SETTLE_CYCLES, register the product
//   and return it tagged with the requester id.
// Ports: clk, rst (sync active-high), bus (mult_share_ctrl_if.slave: request handshakes,
//   response handshake, busy, ops_count).
module mult_share_ctrl
  import mult_ctrl_pkg::*;
#(
  parameter int N_REQ         = 2,
  parameter int SETTLE_CYCLES = 2,
  parameter int ID_W          = id_width(N_REQ)
) (
  input  logic               clk,
  input  logic               rst,
  mult_share_ctrl_if.slave   bus
);

  localparam int CNT_W = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;

  state_t            state;
  logic [ID_W-1:0]   rr_ptr;
  logic [OP_W-1:0]   op_a;
  logic [OP_W-1:0]   op_b;
  logic [ID_W-1:0]   op_id;
  logic [CNT_W-1:0]  cnt;
  logic              rsp_valid_q;
  logic [PROD_W-1:0] rsp_product_q;
  logic [ID_W-1:0]   rsp_id_q;
  logic [15:0]       ops_count_q;

  logic [N_REQ-1:0]  grant;
  logic [ID_W-1:0]   grant_id;
  logic [PROD_W-1:0] mult_out;
  logic              accept;

  mult_rr_arbiter #(
    .N_REQ (N_REQ),
    .ID_W  (ID_W)
  ) u_arb (
    .req   (bus.req_valid),
    .ptr   (rr_ptr),
    .grant (grant),
    .id    (grant_id)
  );

  // The multiplier only ever sees the operand registers, never the live request bus.
  mult_array8 u_mult (
    .a       (op_a),
    .b       (op_b),
    .product (mult_out)
  );

  assign bus.req_ready = (state == ST_IDLE) ? grant : '0;
  assign accept        = |(bus.req_valid & bus.req_ready);

  assign bus.rsp_valid   = rsp_valid_q;
  assign bus.rsp_product = rsp_product_q;
  assign bus.rsp_id      = rsp_id_q;
  assign bus.ops_count   = ops_count_q;
  assign bus.busy        = (state != ST_IDLE);

  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= ST_IDLE;
      rr_ptr        <= '0;
      op_a          <= '0;
      op_b          <= '0;
      op_id         <= '0;
      cnt           <= '0;
      rsp_valid_q   <= 1'b0;
      rsp_product_q <= '0;
      rsp_id_q      <= '0;
      ops_count_q   <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (accept) begin
            op_a  <= bus.req_a[int'(grant_id)*OP_W +: OP_W];
            op_b  <= bus.req_b[int'(grant_id)*OP_W +: OP_W];
            op_id <= grant_id;
            cnt   <= CNT_W'(SETTLE_CYCLES - 1);
            state <= ST_SETTLE;
          end
        end
        ST_SETTLE: begin
          if (cnt == '0) begin
            rsp_product_q <= mult_out;
            rsp_id_q      <= op_id;
            rsp_valid_q   <= 1'b1;
            state         <= ST_DONE;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        ST_DONE: begin
          if (bus.rsp_ready) begin
            rsp_valid_q <= 1'b0;
            ops_count_q <= ops_count_q + 16'd1;
            // The requester just served drops to lowest priority.
            rr_ptr      <= (rsp_id_q == ID_W'(N_REQ - 1)) ? '0 : rsp_id_q + 1'b1;
            state       <= ST_IDLE;
          end
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mult_share_ctrl.sv
// tb/tb_mult_share_ctrl.sv - self-checking bench for mult_share_ctrl
module tb_mult_share_ctrl;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  mult_share_ctrl_if #(.N_REQ(2), .ID_W(1)) bus ();

  mult_share_ctrl #(
    .N_REQ         (2),
    .SETTLE_CYCLES (2),
    .ID_W          (1)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    int          r;
    logic [7:0]  a;
    logic [7:0]  b;
    logic [15:0] prod;
  } vec_t;

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic       id;
  } exp_t;

  int vectors     = 0;
  int miscompares = 0;
  int exp_ops     = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    bus.req_valid = '0;
    bus.rsp_ready = 1'b0;
    tick();
    tick();
    rst = 1'b0;
    exp_ops = 0;
  endtask

  task automatic set_op(input int r, input logic [7:0] a, input logic [7:0] b);
    bus.req_a[8*r +: 8] = a;
    bus.req_b[8*r +: 8] = b;
    bus.req_valid[r]    = 1'b1;
  endtask

  // Waits for a grant, accepts it, checks latency/product/id, optionally stalls the
  // consumer for 'hold' cycles, then completes the response handshake.
  task automatic run_op(input logic [1:0] exp_ready, input logic [15:0] exp_prod,
                        input logic exp_id, input int hold);
    int k;
    #1;
    k = 0;
    while (bus.req_ready == 2'b00 && k < 20) begin
      tick();
      k++;
    end
    chk("req_ready_grant", bus.req_ready, exp_ready);
    tick();
    chk("busy_settle", bus.busy, 1'b1);
    k = 1;
    while (!bus.rsp_valid && k < 20) begin
      tick();
      k++;
    end
    chk("latency", k, 3);
    chk("product", bus.rsp_product, exp_prod);
    chk("rsp_id", bus.rsp_id, exp_id);
    for (int h = 0; h < hold; h++) begin
      tick();
      chk("hold_valid", bus.rsp_valid, 1'b1);
      chk("hold_product", bus.rsp_product, exp_prod);
      chk("hold_id", bus.rsp_id, exp_id);
      chk("hold_req_ready", bus.req_ready, 2'b00);
      chk("hold_busy", bus.busy, 1'b1);
    end
    bus.rsp_ready = 1'b1;
    tick();
    bus.rsp_ready = 1'b0;
    exp_ops++;
    chk("rsp_valid_after_hs", bus.rsp_valid, 1'b0);
    chk("ops_count", bus.ops_count, exp_ops);
  endtask

  vec_t vt[5];
  exp_t q[$];

  initial begin
    vt[0] = '{0, 8'd13,  8'd11,  16'd143};
    vt[1] = '{0, 8'd255, 8'd255, 16'hFE01};
    vt[2] = '{1, 8'd0,   8'd200, 16'd0};
    vt[3] = '{1, 8'd128, 8'd2,   16'd256};
    vt[4] = '{0, 8'd1,   8'd255, 16'd255};

    bus.req_valid = '0;
    bus.req_a     = '0;
    bus.req_b     = '0;
    bus.rsp_ready = 1'b0;

    // Reset state
    do_reset();
    #1;
    chk("reset_rsp_valid", bus.rsp_valid, 1'b0);
    chk("reset_busy", bus.busy, 1'b0);
    chk("reset_ops_count", bus.ops_count, 16'd0);
    chk("reset_product", bus.rsp_product, 16'd0);
    chk("reset_rsp_id", bus.rsp_id, 1'b0);
    chk("reset_req_ready", bus.req_ready, 2'b00);

    // Single-requester vectors, including the width corners
    for (int i = 0; i < 5; i++) begin
      set_op(vt[i].r, vt[i].a, vt[i].b);
      run_op((vt[i].r == 0) ? 2'b01 : 2'b10, vt[i].prod, 1'(vt[i].r), 0);
      bus.req_valid = '0;
    end

    // Both requesters held valid: grants alternate 0,1,0; last response stalled 5 cycles
    do_reset();
    set_op(0, 8'd3, 8'd5);
    set_op(1, 8'd7, 8'd9);
    run_op(2'b01, 16'd15, 1'b0, 0);
    run_op(2'b10, 16'd63, 1'b1, 0);
    run_op(2'b01, 16'd15, 1'b0, 5);
    bus.req_valid = '0;
    tick();

    // Reset in SETTLE aborts the op with no response
    begin
      int k;
      logic seen;
      set_op(1, 8'd9, 8'd9);
      #1;
      k = 0;
      while (bus.req_ready == 2'b00 && k < 20) begin
        tick();
        k++;
      end
      chk("abort_grant", bus.req_ready, 2'b10);
      tick();
      bus.req_valid = '0;
      chk("abort_in_settle", bus.busy, 1'b1);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      exp_ops = 0;
      chk("abort_rsp_valid", bus.rsp_valid, 1'b0);
      chk("abort_busy", bus.busy, 1'b0);
      chk("abort_ops_count", bus.ops_count, 16'd0);
      seen = 1'b0;
      for (int i = 0; i < 8; i++) begin
        tick();
        if (bus.rsp_valid) seen = 1'b1;
      end
      chk("abort_no_response", seen, 1'b0);
    end

    // Random traffic with valid and ready gaps, scoreboard in accept order
    begin
      int accepted = 0;
      int got = 0;
      int cyc = 0;
      logic [1:0] acc;
      exp_t e;
      logic [15:0] p;
      while (got < 1000 && cyc < 30000) begin
        for (int r = 0; r < 2; r++) begin
          if (!bus.req_valid[r] && (accepted + $countones(bus.req_valid)) < 1000 &&
              $urandom_range(0, 2) != 0) begin
            set_op(r, 8'($urandom), 8'($urandom));
          end
        end
        bus.rsp_ready = ($urandom_range(0, 3) != 0);
        #1;
        acc = bus.req_valid & bus.req_ready;
        for (int r = 0; r < 2; r++) begin
          if (acc[r]) begin
            q.push_back('{bus.req_a[8*r +: 8], bus.req_b[8*r +: 8], 1'(r)});
            accepted++;
          end
        end
        if (bus.rsp_valid && bus.rsp_ready) begin
          if (q.size() == 0) begin
            chk("rand_unexpected_rsp", 32'd1, 32'd0);
          end else begin
            e = q.pop_front();
            p = 16'(e.a) * 16'(e.b);
            chk("rand_rsp", {15'd0, bus.rsp_id, bus.rsp_product}, {15'd0, e.id, p});
          end
          got++;
        end
        @(posedge clk);
        #1;
        cyc++;
        bus.req_valid = bus.req_valid & ~acc;
      end
      bus.req_valid = '0;
      bus.rsp_ready = 1'b0;
      chk("rand_resp_count", got, 1000);
      chk("rand_queue_empty", q.size(), 0);
      chk("rand_ops_count", bus.ops_count, 16'd1000);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
